// File: rtl/ntt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ntt_pkg
// Brief  : Shared constants and types for the NTT butterfly datapath.
// Rev    : 1.0  initial release
// ============================================================================
package ntt_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int Q_DEFAULT     = 3329;

    typedef logic [WIDTH_DEFAULT-1:0] coeff_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_e;

endpackage
`default_nettype wire

// File: rtl/mod_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mod_addsub
// Brief  : Combinational modular add and subtract of two residues < Q.
// Rev    : 1.0  initial release
// ============================================================================
module mod_addsub #(
    parameter int WIDTH = 32,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_diff
);

    localparam logic [WIDTH:0] c_Q = (WIDTH+1)'(Q);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_sum_red;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_diff_red;

    assign w_sum     = {1'b0, i_p} + {1'b0, i_q};
    assign w_sum_red = (w_sum >= c_Q) ? (w_sum - c_Q) : w_sum;

    // Wrapped difference plus Q lands back in [0, Q) when p < q.
    assign w_diff     = {1'b0, i_p} - {1'b0, i_q};
    assign w_diff_red = (i_p < i_q) ? (w_diff + c_Q) : w_diff;

    assign o_sum  = WIDTH'(w_sum_red);
    assign o_diff = WIDTH'(w_diff_red);

endmodule
`default_nettype wire

// File: rtl/mod_mult.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mod_mult
// Brief  : Combinational modular multiply, o_p = (i_a * i_b) mod Q.
// Rev    : 1.0  initial release
// ============================================================================
module mod_mult #(
    parameter int WIDTH = 32,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p
);

    localparam logic [2*WIDTH-1:0] c_Q_WIDE = (2*WIDTH)'(Q);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_rem;

    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_rem  = w_prod % c_Q_WIDE;
    assign o_p    = WIDTH'(w_rem);

endmodule
`default_nettype wire

// File: rtl/ntt_butterfly.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ntt_butterfly
// Brief  : Two-stage pipelined CT/GS radix-2 butterfly with whole-pipe stall.
// Rev    : 1.0  initial release
// ============================================================================
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int Q     = Q_DEFAULT,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag
);

    logic             w_adv;
    logic [WIDTH-1:0] w_ct_prod;
    logic [WIDTH-1:0] w_s1_sum;
    logic [WIDTH-1:0] w_s1_diff;
    logic [WIDTH-1:0] w_s1_p;
    logic [WIDTH-1:0] w_s1_q;
    logic [WIDTH-1:0] w_gs_prod;
    logic [WIDTH-1:0] w_s2_sum;
    logic [WIDTH-1:0] w_s2_diff;
    logic [WIDTH-1:0] w_s2_x;
    logic [WIDTH-1:0] w_s2_y;

    logic             r_s1_valid;
    bf_mode_e         r_s1_mode;
    logic [TAG_W-1:0] r_s1_tag;
    logic [WIDTH-1:0] r_s1_w;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_q;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out_x;
    logic [WIDTH-1:0] r_out_y;
    logic [TAG_W-1:0] r_out_tag;

    // Whole pipeline advances together; an empty output slot always frees it.
    assign w_adv    = !r_s2_valid || out_ready;
    assign in_ready = w_adv;

    mod_mult #(.WIDTH(WIDTH), .Q(Q)) u_mult_ct (
        .i_a (in_w),
        .i_b (in_b),
        .o_p (w_ct_prod)
    );

    mod_addsub #(.WIDTH(WIDTH), .Q(Q)) u_addsub_s1 (
        .i_p    (in_a),
        .i_q    (in_b),
        .o_sum  (w_s1_sum),
        .o_diff (w_s1_diff)
    );

    assign w_s1_p = (in_mode == BF_GS) ? w_s1_sum  : in_a;
    assign w_s1_q = (in_mode == BF_GS) ? w_s1_diff : w_ct_prod;

    mod_mult #(.WIDTH(WIDTH), .Q(Q)) u_mult_gs (
        .i_a (r_s1_q),
        .i_b (r_s1_w),
        .o_p (w_gs_prod)
    );

    mod_addsub #(.WIDTH(WIDTH), .Q(Q)) u_addsub_s2 (
        .i_p    (r_s1_p),
        .i_q    (r_s1_q),
        .o_sum  (w_s2_sum),
        .o_diff (w_s2_diff)
    );

    assign w_s2_x = (r_s1_mode == BF_GS) ? r_s1_p    : w_s2_sum;
    assign w_s2_y = (r_s1_mode == BF_GS) ? w_gs_prod : w_s2_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= BF_CT;
            r_s1_tag   <= '0;
            r_s1_w     <= '0;
            r_s1_p     <= '0;
            r_s1_q     <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_mode  <= bf_mode_e'(in_mode);
            r_s1_tag   <= in_tag;
            r_s1_w     <= in_w;
            r_s1_p     <= w_s1_p;
            r_s1_q     <= w_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_x    <= '0;
            r_out_y    <= '0;
            r_out_tag  <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_out_x    <= w_s2_x;
            r_out_y    <= w_s2_y;
            r_out_tag  <= r_s1_tag;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ntt_butterfly
// Brief  : Self-checking bench for ntt_butterfly (scoreboard + directed vectors).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ntt_butterfly;
    import ntt_pkg::*;

    localparam int W  = 32;
    localparam int QM = 3329;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    coeff_t        in_a, in_b, in_w;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    coeff_t        out_x, out_y;
    logic [TW-1:0] out_tag;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [TW-1:0] tag;
    } exp_t;
    exp_t q_exp[$];

    ntt_butterfly #(.WIDTH(W), .Q(QM), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_tag   (out_tag)
    );

    initial forever #5 clk = ~clk;

    // Butterfly results straight from the modular-arithmetic definitions.
    function automatic void model(input logic mode, input longint a, input longint b,
                                  input longint w, output longint x, output longint y);
        longint wb;
        if (mode == 1'b0) begin
            wb = (w * b) % QM;
            x  = (a + wb) % QM;
            y  = (a - wb + QM) % QM;
        end else begin
            x  = (a + b) % QM;
            y  = (((a - b + QM) % QM) * w) % QM;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic          stall_prev;
        logic [W-1:0]  px, py;
        logic [TW-1:0] pt;
        exp_t          e;
        longint        mx, my;
        stall_prev = 1'b0;
        px = '0; py = '0; pt = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q_exp.delete();
                stall_prev = 1'b0;
            end else begin
                check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
                if (stall_prev) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_x", 64'(out_x), 64'(px));
                    check("hold_y", 64'(out_y), 64'(py));
                    check("hold_tag", 64'(out_tag), 64'(pt));
                end
                if (out_valid && out_ready) begin
                    if (q_exp.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got tag %0d expected no beat at %0t",
                                 out_tag, $time);
                    end else begin
                        e = q_exp.pop_front();
                        check("sb_x", 64'(out_x), 64'(e.x));
                        check("sb_y", 64'(out_y), 64'(e.y));
                        check("sb_tag", 64'(out_tag), 64'(e.tag));
                    end
                end
                if (in_valid && in_ready) begin
                    model(in_mode, longint'(in_a), longint'(in_b), longint'(in_w), mx, my);
                    e.x   = W'(mx);
                    e.y   = W'(my);
                    e.tag = in_tag;
                    q_exp.push_back(e);
                end
                stall_prev = out_valid && !out_ready;
                px = out_x;
                py = out_y;
                pt = out_tag;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic mode, input int a, input int b, input int w,
                        input int tag, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = W'(a);
        in_b     = W'(b);
        in_w     = W'(w);
        in_tag   = tag[TW-1:0];
        do begin
            @(negedge clk);
            if (!in_ready) waits++;
        end while (!in_ready && waits < 200);
        if (waits >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept for tag %0d expected accept", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input logic mode, input int a, input int b, input int w,
                           input int tag, input int ex, input int ey);
        int waits;
        out_ready = 1'b1;
        send(mode, a, b, w, tag, waits);
        @(negedge clk);
        check("lat_not_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lit_x", 64'(out_x), 64'(ex));
        check("lit_y", 64'(out_y), 64'(ey));
        check("lit_tag", 64'(out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 64'(q_exp.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint mx, my;
        int     waits, tot;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_w      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_x", 64'(out_x), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        model(1'b0, 5, 7, 10, mx, my);
        check("model_ct_x", 64'(mx), 64'd75);
        check("model_ct_y", 64'(my), 64'd3264);
        model(1'b1, 100, 200, 3, mx, my);
        check("model_gs_x", 64'(mx), 64'd300);
        check("model_gs_y", 64'(my), 64'd3029);

        run_one(1'b0, 5, 7, 10, 8'h11, 75, 3264);
        run_one(1'b1, 100, 200, 3, 8'h12, 300, 3029);
        run_one(1'b0, 3328, 1, 1, 8'h13, 0, 3327);
        run_one(1'b0, 0, 0, 0, 8'h14, 0, 0);
        run_one(1'b1, 0, 3328, 3328, 8'h15, 3328, 3328);
        drain();

        // Full rate with the consumer always ready.
        out_ready = 1'b1;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)), $urandom_range(0, QM-1), $urandom_range(0, QM-1),
                 $urandom_range(0, QM-1), 8'h20 + i, waits);
            tot += waits;
        end
        check("throughput_waits", 64'(tot), 64'd0);
        drain();

        // Backpressure: consumer stalls while four beats are offered.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(1'(i % 2), 100 * i, 37 * i, 11 * i, i, waits);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_first_tag", 64'(out_tag), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++)
            send(1'($urandom_range(0, 1)), $urandom_range(0, QM-1), $urandom_range(0, QM-1),
                 $urandom_range(0, QM-1), i, waits);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight.
        send(1'b0, 1, 2, 3, 8'hA0, waits);
        send(1'b1, 4, 5, 6, 8'hA1, waits);
        check("mid_inflight", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_x", 64'(out_x), 64'd0);
        check("mid_rst_y", 64'(out_y), 64'd0);
        check("mid_rst_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        run_one(1'b0, 5, 7, 10, 8'hB0, 75, 3264);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
